beacon_burst_seq: RTL
=====================

# beacon_burst_seq

Parametrised trigger-to-burst sequencer for the beacon transmitter path. A rising edge on `trig` starts a programmable delay, then a gated burst window on one or more output-enable channels, then a holdoff lockout. This generalises the single-channel, fixed-count wait/enable/lockout logic to N channels, parallel or round-robin mode, runtime counts, abort, and missed-trigger accounting. It sits between the trigger source (hex dump / UART command strobe) and the `SB_IO` `OUTPUT_ENABLE` pins of the transmit pads.

## Interface
- `CH`, 2, number of output channels (1..8)
- `DW`, 11, delay counter width
- `BW`, 10, burst counter width
- `HW`, 11, holdoff counter width
- `clk` in 1: system clock (48 MHz)
- `rst` in 1: asynchronous, active-low reset
- `trig` in 1: trigger level, synchronous to `clk`; rising edge starts a cycle
- `abort` in 1: synchronous abort, level
- `mode` in 1: 0 = parallel (all masked channels together), 1 = sequential (one channel at a time, ascending index)
- `ch_mask` in CH: channels participating
- `delay_cyc` in DW: delay D in cycles
- `burst_cyc` in BW: burst length B in cycles; 0 is treated as 1
- `holdoff_cyc` in HW: lockout H in cycles
- `burst_en` out CH: registered per-channel output enable
- `busy` out 1: high in DELAY, BURST, HOLDOFF
- `done` out 1: one-cycle pulse on normal completion
- `missed` out 8: saturating count of rejected triggers

## Operation
- Edge detect: `rise = trig & ~trig_q`. `trig_q` resets to 1, so a high `trig` at reset release does not start a cycle.
- States: IDLE, DELAY, BURST, HOLDOFF.
- IDLE:
  - On `rise` with `ch_mask != 0`: latch `mode`, `ch_mask`, D, B, H into shadow registers, then go to DELAY.
  - On `rise` with `ch_mask == 0`: ignore; no count, no `done`.
- DELAY: count D cycles, then go to BURST. D = 0 enters BURST on the next edge.
- BURST, parallel mode: `burst_en = shadow mask` for B cycles.
- BURST, sequential mode: each set mask bit, lowest first, gets B consecutive cycles with no gap. At most one `burst_en` bit is high at a time.
- After the last burst slot, go to HOLDOFF.
- HOLDOFF: all `burst_en` low for H cycles. Then go to IDLE and pulse `done` for one cycle. H = 0 returns to IDLE on the next edge.
- `rise` while `busy`:
  - `missed` increments, saturating at 255, cleared only by reset.
  - The trigger is not queued.
- `abort` high in any non-IDLE state: go to IDLE on the next edge, `burst_en` to 0, no `done`. `abort` has priority over every other transition. `abort` in IDLE suppresses acceptance of a coincident `rise`, which is not counted as missed.
- Runtime config inputs changing mid-cycle have no effect. Only the shadow copies are used.
- Counters are sized to their parameter widths. No wrap is possible because each count is loaded once and decremented to 0.

## Timing
- Reset (`rst` low, asynchronous): state IDLE, `burst_en` = 0, `busy` = 0, `done` = 0, `missed` = 0, `trig_q` = 1.
- Let E0 be the clock edge at which `rise` is accepted.
- `busy` rises at E0 and falls at the edge on which `done` rises.
- The first `burst_en` bit rises at edge E0+D+1.
- Total `burst_en`-high span:
  - B cycles in parallel mode.
  - B × popcount(mask) cycles in sequential mode.
- `done` is high for the single cycle after the last HOLDOFF cycle. In that same cycle, a new `rise` is accepted; it is not counted as missed.
- Total cycle length, E0 to the `done` edge: D + 1 + burst span + H cycles.
- All outputs are registered. There are no combinational input-to-output paths.

## Test plan
- Reset with `trig` held high, then release:
  - No `busy`, `missed` = 0.
  - `trig` low, then high, starts a cycle.
- Parallel mode, mask = 2'b11, D = 5, B = 4, H = 3, single rise at E0:
  - `burst_en` = 2'b11 during edges E0+6..E0+9.
  - `done` pulses at E0+13.
  - `busy` is high E0..E0+12.
- Sequential mode, mask = 2'b11, D = 0, B = 3, H = 0:
  - `burst_en` = 01 for edges E0+1..E0+3, then 10 for edges E0+4..E0+6.
  - Never both bits high.
  - `done` at E0+7.
- Three rises during one active cycle:
  - `missed` = 3 and the cycle is unaffected.
  - 300 rises while busy leave `missed` = 255.
- `abort` asserted on the 2nd `burst_en` cycle:
  - `burst_en` = 0 and state IDLE on the next edge.
  - No `done`.
  - The next rise is accepted normally.
- Config changed mid-DELAY (B 4 to 9) gives a burst of 4. `ch_mask` = 0 on a rise gives no activity and `missed` unchanged.

Source files
------------

// File: rtl/beacon_burst_seq.sv
// beacon_burst_seq: trigger-to-burst sequencer for the beacon transmit pads.
// A rising edge on trig starts DELAY (D cycles), then BURST (B cycles on all
// masked channels, or B cycles per masked channel in ascending order), then
// HOLDOFF (H cycles), then a one-cycle done pulse.
//
// Ports:
//   clk         system clock
//   rst         asynchronous active-low reset
//   trig        trigger level; rising edge starts a cycle
//   abort       synchronous abort level; returns to idle without done
//   mode        0 = parallel, 1 = sequential (one channel at a time)
//   ch_mask     participating channels
//   delay_cyc   delay D in cycles
//   burst_cyc   burst length B in cycles (0 behaves as 1)
//   holdoff_cyc lockout H in cycles
//   burst_en    registered per-channel output enable
//   busy        high while a cycle is in progress
//   done        one-cycle pulse on normal completion
//   missed      saturating count of triggers rejected while busy
module beacon_burst_seq #(
    parameter int unsigned CH = 2,
    parameter int unsigned DW = 11,
    parameter int unsigned BW = 10,
    parameter int unsigned HW = 11
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          trig,
    input  logic          abort,
    input  logic          mode,
    input  logic [CH-1:0] ch_mask,
    input  logic [DW-1:0] delay_cyc,
    input  logic [BW-1:0] burst_cyc,
    input  logic [HW-1:0] holdoff_cyc,
    output logic [CH-1:0] burst_en,
    output logic          busy,
    output logic          done,
    output logic [7:0]    missed
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StDelay = 2'd1;
    localparam logic [1:0] StBurst = 2'd2;
    localparam logic [1:0] StHold  = 2'd3;

    logic [1:0]    state_q, state_d;
    logic          trig_q;
    logic          mode_q, mode_d;
    logic [CH-1:0] mask_q, mask_d;
    logic [CH-1:0] rem_q, rem_d;       // channels still owed a sequential slot
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic [BW-1:0] blen_q, blen_d;     // effective burst length minus one
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [HW-1:0] hcnt_q, hcnt_d;
    logic [CH-1:0] burst_en_q, burst_en_d;
    logic          done_q, done_d;
    logic [7:0]    missed_q, missed_d;

    logic          rise;
    logic          active;
    logic [CH-1:0] cur_slot;
    logic [CH-1:0] rem_next;

    // Isolate the lowest set bit.
    function automatic logic [CH-1:0] low_bit(input logic [CH-1:0] v);
        return v & (~v + CH'(1));
    endfunction

    assign rise     = trig & ~trig_q;
    assign active   = (state_q != StIdle);
    assign cur_slot = low_bit(rem_q);
    assign rem_next = rem_q & ~cur_slot;

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        mask_d     = mask_q;
        rem_d      = rem_q;
        dcnt_d     = dcnt_q;
        blen_d     = blen_q;
        bcnt_d     = bcnt_q;
        hold_d     = hold_q;
        hcnt_d     = hcnt_q;
        burst_en_d = burst_en_q;
        done_d     = 1'b0;
        missed_d   = missed_q;

        case (state_q)
            StIdle: begin
                if (rise && !abort && (ch_mask != '0)) begin
                    mode_d  = mode;
                    mask_d  = ch_mask;
                    dcnt_d  = delay_cyc;
                    blen_d  = (burst_cyc == '0) ? '0 : burst_cyc - BW'(1);
                    hold_d  = holdoff_cyc;
                    state_d = StDelay;
                end
            end
            StDelay: begin
                if (dcnt_q == '0) begin
                    state_d    = StBurst;
                    bcnt_d     = blen_q;
                    rem_d      = mask_q;
                    burst_en_d = mode_q ? low_bit(mask_q) : mask_q;
                end else begin
                    dcnt_d = dcnt_q - DW'(1);
                end
            end
            StBurst: begin
                if (bcnt_q != '0) begin
                    bcnt_d = bcnt_q - BW'(1);
                end else if (mode_q && (rem_next != '0)) begin
                    // Next channel follows with no gap.
                    rem_d      = rem_next;
                    burst_en_d = low_bit(rem_next);
                    bcnt_d     = blen_q;
                end else begin
                    burst_en_d = '0;
                    // H = 0 skips HOLDOFF so total length stays D+1+span+H.
                    if (hold_q == '0) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end else begin
                        state_d = StHold;
                        hcnt_d  = hold_q - HW'(1);
                    end
                end
            end
            StHold: begin
                if (hcnt_q == '0) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end else begin
                    hcnt_d = hcnt_q - HW'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        if (abort && active) begin
            state_d    = StIdle;
            burst_en_d = '0;
            done_d     = 1'b0;
        end

        if (rise && active && (missed_q != 8'hFF)) begin
            missed_d = missed_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            trig_q     <= 1'b1;
            mode_q     <= 1'b0;
            mask_q     <= '0;
            rem_q      <= '0;
            dcnt_q     <= '0;
            blen_q     <= '0;
            bcnt_q     <= '0;
            hold_q     <= '0;
            hcnt_q     <= '0;
            burst_en_q <= '0;
            done_q     <= 1'b0;
            missed_q   <= '0;
        end else begin
            state_q    <= state_d;
            trig_q     <= trig;
            mode_q     <= mode_d;
            mask_q     <= mask_d;
            rem_q      <= rem_d;
            dcnt_q     <= dcnt_d;
            blen_q     <= blen_d;
            bcnt_q     <= bcnt_d;
            hold_q     <= hold_d;
            hcnt_q     <= hcnt_d;
            burst_en_q <= burst_en_d;
            done_q     <= done_d;
            missed_q   <= missed_d;
        end
    end

    assign burst_en = burst_en_q;
    assign busy     = active;
    assign done     = done_q;
    assign missed   = missed_q;

endmodule
